// File: rtl/bus_arbiter_2to1.sv
// bus_arbiter_2to1
// Lets two requesters (port 0 = instruction fetch, port 1 = load/store) share one
// memory bus. Ports take turns (round-robin). A grant that is stalled by the memory
// stays locked to its owner until the handshake completes. Responses come back in
// order, and a small FIFO of owner IDs steers each response to the requester that
// issued it.
module bus_arbiter_2to1 #(
   parameter int AddrWidth      = 32,
   parameter int DataWidth      = 32,
   parameter int MaxOutstanding = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [1:0]                 rq_valid_i,
   output logic [1:0]                 rq_ready_o,
   input  logic [2*AddrWidth-1:0]     rq_addr_i,
   input  logic [2*DataWidth-1:0]     rq_wdata_i,
   input  logic [2*DataWidth/8-1:0]   rq_wmask_i,
   output logic [1:0]                 rq_rvalid_o,
   output logic [DataWidth-1:0]       rq_rdata_o,
   output logic                       mem_valid_o,
   input  logic                       mem_ready_i,
   output logic [AddrWidth-1:0]       mem_addr_o,
   output logic [DataWidth-1:0]       mem_wdata_o,
   output logic [DataWidth/8-1:0]     mem_wmask_o,
   input  logic                       mem_rvalid_i,
   input  logic [DataWidth-1:0]       mem_rdata_i,
   output logic                       err_o
);

   localparam int MaskWidth = DataWidth / 8;
   localparam int PtrW      = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int CntW      = $clog2(MaxOutstanding + 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
   localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);

   logic            r_lock;
   logic            r_lockId;
   logic            r_prio;
   logic            r_err;
   logic [CntW-1:0] r_count;
   logic [PtrW-1:0] r_wrPtr;
   logic [PtrW-1:0] r_rdPtr;
   logic            r_idFifo [MaxOutstanding];

   logic            w_owner;
   logic            w_full;
   logic            w_memHs;
   logic            w_push;
   logic            w_pop;
   logic            w_headId;

   assign w_full   = (r_count == MaxCnt);
   assign w_headId = r_idFifo[r_rdPtr];
   assign w_memHs  = mem_valid_o && mem_ready_i;
   assign w_push   = w_memHs;
   assign w_pop    = mem_rvalid_i && (r_count != '0);
   assign err_o    = r_err;

   // Pick the owner of the bus: a locked owner wins outright, otherwise priority breaks ties
   always_comb begin
      w_owner = 1'b0;
      if (r_lock) begin
         w_owner = r_lockId;
      end else if (rq_valid_i == 2'b11) begin
         w_owner = r_prio;
      end else if (rq_valid_i[1]) begin
         w_owner = 1'b1;
      end
   end

   // Steer the owner's request onto the memory bus and return its accept
   always_comb begin
      mem_valid_o = 1'b0;
      rq_ready_o  = 2'b00;
      mem_addr_o  = w_owner ? rq_addr_i[AddrWidth +: AddrWidth]  : rq_addr_i[0 +: AddrWidth];
      mem_wdata_o = w_owner ? rq_wdata_i[DataWidth +: DataWidth] : rq_wdata_i[0 +: DataWidth];
      mem_wmask_o = w_owner ? rq_wmask_i[MaskWidth +: MaskWidth] : rq_wmask_i[0 +: MaskWidth];
      if (rst_ni) begin
         mem_valid_o = rq_valid_i[w_owner] && !w_full;
         if (mem_ready_i && !w_full) begin
            rq_ready_o[w_owner] = 1'b1;
         end
      end
   end

   // Route a memory response to whichever requester sits at the FIFO head
   always_comb begin
      rq_rvalid_o = 2'b00;
      rq_rdata_o  = mem_rdata_i;
      if (rst_ni && w_pop) begin
         rq_rvalid_o[w_headId] = 1'b1;
      end
   end

   // Grant lock and round-robin priority: hold a stalled grant, then hand priority to the other port
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_lock   <= 1'b0;
         r_lockId <= 1'b0;
         r_prio   <= 1'b0;
      end else begin
         if (mem_valid_o && !mem_ready_i) begin
            r_lock   <= 1'b1;
            r_lockId <= w_owner;
         end else if (w_memHs) begin
            r_lock <= 1'b0;
         end
         if (w_memHs) begin
            r_prio <= ~w_owner;
         end
      end
   end

   // In-order owner-ID FIFO: push on request handshake, pop on response
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         for (int i = 0; i < MaxOutstanding; i++) begin
            r_idFifo[i] <= 1'b0;
         end
      end else begin
         if (w_push) begin
            r_idFifo[r_wrPtr] <= w_owner;
            r_wrPtr           <= (r_wrPtr == LastPtr) ? '0 : r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= (r_rdPtr == LastPtr) ? '0 : r_rdPtr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky error flag: a response arrived while nothing was outstanding
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_err <= 1'b0;
      end else if (mem_rvalid_i && (r_count == '0)) begin
         r_err <= 1'b1;
      end
   end

endmodule
